aui_am_lock: RTL and testbench
==============================

// Module: aui_am_lock
// PURPOSE
// Per-lane receive-side alignment-marker (AM) lock and strip stage. Sits directly downstream of
// the AUI transmit generator / lane channel, one instance per lane. Finds the periodic 2-word AM
// pair in a word-aligned 64-bit stream and qualifies lock over consecutive markers. Removes AM
// words and forwards only payload words, flagging lock state and per-marker check results.
// PARAMETERS
// DATA_WIDTH  64                     lane word width (bits)
// AM_HI       64'h9A4A26B665B5D9D9   first AM word (sent first)
// AM_LO       64'hFE8E0C260171F355   second AM word
// AM_PERIOD   20                     payload words between AM pairs; frame F = AM_PERIOD+2 words
// LOCK_CNT    3                      consecutive good AM pairs (incl. first find) needed to lock
// UNLOCK_CNT  4                      consecutive bad AM pairs while locked that drop lock
// PORTS
// clk         in   1           clock
// rst_n       in   1           asynchronous active-low reset
// i_valid     in   1           i_data holds a lane word this cycle
// i_data      in   DATA_WIDTH  lane word, already word-aligned
// o_valid     out  1           o_data is a payload word
// o_data      out  DATA_WIDTH  payload word (AM words never presented with o_valid=1)
// o_locked    out  1           level: FSM in LOCKED
// o_am_ok     out  1           1-cycle pulse: expected AM pair matched (VERIFY or LOCKED)
// o_am_err    out  1           1-cycle pulse: expected AM pair mismatched (VERIFY or LOCKED)
// BEHAVIOUR
// - Reset is asynchronous. Every output resets to 0. FSM resets to SEARCH. pos, good_cnt,
//   bad_cnt and hi_match reset to 0.
// - i_valid=0: no state changes. o_valid, o_am_ok and o_am_err are 0 the next cycle.
//   All counting is in valid words, not cycles.
// - pos (width $clog2(F)) counts valid words within the frame, 0..F-1, then wraps to 0.
//   Payload occupies pos 0..AM_PERIOD-1, AM_HI is expected at pos AM_PERIOD, AM_LO at AM_PERIOD+1.
// - Pair check: at pos AM_PERIOD, latch hi_match = (i_data==AM_HI). At pos AM_PERIOD+1,
//   pair_good = hi_match && (i_data==AM_LO). Each pair is judged once, on its AM_LO word.
// - SEARCH:
//   - Every valid word is compared against the pattern.
//   - When the previous valid word equals AM_HI and the current one equals AM_LO:
//     go to VERIFY, set good_cnt=1, set pos so the next valid word is pos 0. No o_am_ok pulse.
// - VERIFY:
//   - pair_good: good_cnt++ and pulse o_am_ok.
//   - good_cnt reaching LOCK_CNT moves the FSM to LOCKED in that same cycle, so o_locked is 1
//     in the cycle after that AM_LO is accepted.
//   - !pair_good: pulse o_am_err, go to SEARCH, set good_cnt=0.
//   - The SEARCH comparison is re-armed starting with the next word.
// - LOCKED:
//   - pair_good: set bad_cnt=0 and pulse o_am_ok.
//   - !pair_good: bad_cnt++ and pulse o_am_err.
//   - bad_cnt reaching UNLOCK_CNT: go to SEARCH, clear good_cnt and bad_cnt, o_locked=0
//     next cycle.
//   - Lock is held through fewer than UNLOCK_CNT consecutive bad pairs. Position is never
//     re-derived while LOCKED.
// - Output, latency 1:
//   - o_data is i_data registered every valid word.
//   - o_valid = registered (i_valid && state==LOCKED && pos<AM_PERIOD).
//   - AM positions are suppressed by position, even when their content mismatched.
//   - The AM pair that completes lock is not output. The first o_valid is payload pos 0
//     after lock.
//   - o_valid deasserts with the word following the AM_LO on which lock was dropped.
// - Simultaneous events: a bad pair with bad_cnt==UNLOCK_CNT-1 pulses o_am_err and drops lock
//   in the same cycle. The counters saturate and never wrap.
// - Reset asserted mid-frame clears everything; lock must be fully re-acquired.
// TESTING
// - Reset: assert rst_n=0 mid-stream -> all outputs 0 within the same cycle. FSM returns to
//   SEARCH, o_locked stays 0 until 3 fresh AM pairs.
// - Clean stream: AM pair every 22 words, payload = incrementing count -> o_am_ok pulses on the
//   2nd and 3rd pair. o_locked=1 one cycle after the 3rd AM_LO. o_data then gives 20 payload
//   words per frame, in order, with no AM words.
// - Single bad AM while locked: AM_LO of one pair = 0 -> one o_am_err pulse, o_locked stays 1.
//   The 20 payload words are still forwarded and the next good pair resets bad_cnt.
// - Lock loss: 4 consecutive pairs with AM_HI corrupted -> 4 o_am_err pulses, o_locked falls
//   one cycle after the 4th AM_LO position, o_valid stays 0 afterwards.
// - False lock: one isolated AM pair, then no AM at pos 20/21 -> o_am_err pulse, FSM back to
//   SEARCH, o_locked never asserts.
// - Gapped input: i_valid low every 3rd cycle on the clean stream -> same lock point in valid
//   words and an identical payload sequence on o_data.

Source files
------------

// File: rtl/aui_am_lock_if.sv
// Lane bus between the AUI lane channel and the per-lane AM lock/strip stage.
interface aui_am_lock_if #(
  parameter int unsigned DataWidth = 64
);
  logic                 i_valid;
  logic [DataWidth-1:0] i_data;
  logic                 o_valid;
  logic [DataWidth-1:0] o_data;
  logic                 o_locked;
  logic                 o_am_ok;
  logic                 o_am_err;

  // Lane source / payload sink side.
  modport master (
    output i_valid, i_data,
    input  o_valid, o_data, o_locked, o_am_ok, o_am_err
  );

  // AM lock stage side.
  modport slave (
    input  i_valid, i_data,
    output o_valid, o_data, o_locked, o_am_ok, o_am_err
  );
endinterface

// File: rtl/aui_am_lock.sv
// Per-lane receive alignment-marker lock and strip: finds the periodic AM_HI/AM_LO pair,
// qualifies lock over consecutive pairs and forwards only payload words once locked.
module aui_am_lock #(
  parameter int unsigned          DataWidth = 64,
  parameter logic [DataWidth-1:0] AmHi      = 64'h9A4A26B665B5D9D9,
  parameter logic [DataWidth-1:0] AmLo      = 64'hFE8E0C260171F355,
  parameter int unsigned          AmPeriod  = 20,
  parameter int unsigned          LockCnt   = 3,
  parameter int unsigned          UnlockCnt = 4
) (
  input logic              clk,
  input logic              rst_n,
  aui_am_lock_if.slave     lane_io
);

  localparam int unsigned Frame = AmPeriod + 2;
  localparam int unsigned PosW  = $clog2(Frame);
  localparam int unsigned GoodW = $clog2(LockCnt + 1);
  localparam int unsigned BadW  = $clog2(UnlockCnt + 1);

  localparam logic [PosW-1:0]  PosHi     = PosW'(AmPeriod);
  localparam logic [PosW-1:0]  PosLo     = PosW'(AmPeriod + 1);
  localparam logic [PosW-1:0]  PosLast   = PosW'(Frame - 1);
  localparam logic [GoodW-1:0] GoodLock  = GoodW'(LockCnt);
  localparam logic [BadW-1:0]  BadUnlock = BadW'(UnlockCnt);

  typedef enum logic [1:0] {StSearch, StVerify, StLocked} state_e;

  state_e               state_q, state_d;
  logic [PosW-1:0]      pos_q, pos_d;
  logic [GoodW-1:0]     good_cnt_q, good_cnt_d;
  logic [BadW-1:0]      bad_cnt_q, bad_cnt_d;
  logic                 hi_match_q, hi_match_d;
  logic                 prev_hi_q, prev_hi_d;
  logic                 valid_q, valid_d;
  logic                 am_ok_q, am_ok_d;
  logic                 am_err_q, am_err_d;
  logic [DataWidth-1:0] data_q;

  logic             word_hi, word_lo, pair_good;
  logic [GoodW-1:0] good_next;
  logic [BadW-1:0]  bad_next;

  assign word_hi   = (lane_io.i_data == AmHi);
  assign word_lo   = (lane_io.i_data == AmLo);
  assign pair_good = hi_match_q && word_lo;
  // Saturating increments; counters never wrap.
  assign good_next = (good_cnt_q == GoodLock) ? good_cnt_q : good_cnt_q + GoodW'(1);
  assign bad_next  = (bad_cnt_q == BadUnlock) ? bad_cnt_q : bad_cnt_q + BadW'(1);

  // Next-state: pattern search, frame position tracking and pair qualification.
  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    hi_match_d = hi_match_q;
    prev_hi_d  = prev_hi_q;
    am_ok_d    = 1'b0;
    am_err_d   = 1'b0;
    // AM slots are dropped by position alone, whatever their content.
    valid_d    = lane_io.i_valid && (state_q == StLocked) && (pos_q < PosHi);

    if (lane_io.i_valid) begin
      case (state_q)
        StSearch: begin
          prev_hi_d = word_hi;
          if (prev_hi_q && word_lo) begin
            state_d    = StVerify;
            good_cnt_d = GoodW'(1);
            pos_d      = '0;
            hi_match_d = 1'b0;
            prev_hi_d  = 1'b0;
          end
        end

        StVerify, StLocked: begin
          pos_d = (pos_q == PosLast) ? '0 : pos_q + PosW'(1);
          if (pos_q == PosHi) begin
            hi_match_d = word_hi;
          end
          if (pos_q == PosLo) begin
            if (state_q == StVerify) begin
              if (pair_good) begin
                am_ok_d    = 1'b1;
                good_cnt_d = good_next;
                if (good_next == GoodLock) begin
                  state_d = StLocked;
                end
              end else begin
                am_err_d   = 1'b1;
                state_d    = StSearch;
                good_cnt_d = '0;
                prev_hi_d  = 1'b0;
              end
            end else begin
              if (pair_good) begin
                am_ok_d   = 1'b1;
                bad_cnt_d = '0;
              end else begin
                am_err_d  = 1'b1;
                bad_cnt_d = bad_next;
                if (bad_next == BadUnlock) begin
                  state_d    = StSearch;
                  good_cnt_d = '0;
                  bad_cnt_d  = '0;
                  prev_hi_d  = 1'b0;
                end
              end
            end
          end
        end

        default: begin
          state_d = StSearch;
        end
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StSearch;
      pos_q      <= '0;
      good_cnt_q <= '0;
      bad_cnt_q  <= '0;
      hi_match_q <= 1'b0;
      prev_hi_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      good_cnt_q <= good_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
      hi_match_q <= hi_match_d;
      prev_hi_q  <= prev_hi_d;
    end
  end

  // Registered outputs, one cycle behind the accepted word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      am_ok_q  <= 1'b0;
      am_err_q <= 1'b0;
      data_q   <= '0;
    end else begin
      valid_q  <= valid_d;
      am_ok_q  <= am_ok_d;
      am_err_q <= am_err_d;
      if (lane_io.i_valid) begin
        data_q <= lane_io.i_data;
      end
    end
  end

  assign lane_io.o_valid  = valid_q;
  assign lane_io.o_data   = data_q;
  assign lane_io.o_locked = (state_q == StLocked);
  assign lane_io.o_am_ok  = am_ok_q;
  assign lane_io.o_am_err = am_err_q;

endmodule

// File: tb/tb_aui_am_lock.sv
// Bench for aui_am_lock: directed scenario sequence with randomized payload, gaps and
// corruption, checked every cycle against a frame-level reference model.
module tb_aui_am_lock;

  localparam logic [63:0] AmHi = 64'h9A4A26B665B5D9D9;
  localparam logic [63:0] AmLo = 64'hFE8E0C260171F355;
  localparam int P       = 20;
  localparam int F       = P + 2;
  localparam int LockN   = 3;
  localparam int UnlockN = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aui_am_lock_if #(.DataWidth(64)) lane ();

  aui_am_lock dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .lane_io (lane)
  );

  int vectors = 0;
  int errors  = 0;

  // Reference model: is frame position known, are we locked, run lengths of good/bad pairs.
  bit m_sync, m_lock, m_prev_hi, m_hi_seen;
  int m_fpos, m_good, m_bad;
  logic        e_valid, e_ok, e_err, e_locked;
  logic [63:0] e_data;

  // Observations.
  int ok_cnt, err_cnt, vw_sent, lock_at, out_cnt, gap_mode, cyc, k;
  bit lock_fell, lock_rose, prev_locked, collect;
  logic [63:0] outq[$];
  logic [63:0] refq[$];
  logic [63:0] pay, base;

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sync = 0; m_lock = 0; m_prev_hi = 0; m_hi_seen = 0;
    m_fpos = 0; m_good = 0; m_bad = 0;
    e_valid = 0; e_ok = 0; e_err = 0; e_locked = 0; e_data = '0;
  endtask

  // One accepted lane word; sets the outputs expected in the following cycle.
  task automatic model_word(input logic [63:0] d);
    bit good;
    e_ok    = 0;
    e_err   = 0;
    e_data  = d;
    e_valid = m_lock && (m_fpos < P);
    if (!m_sync) begin
      if (m_prev_hi && d == AmLo) begin
        m_sync = 1; m_good = 1; m_fpos = 0; m_prev_hi = 0;
      end else begin
        m_prev_hi = (d == AmHi);
      end
    end else begin
      if (m_fpos == P) m_hi_seen = (d == AmHi);
      if (m_fpos == P + 1) begin
        good = m_hi_seen && (d == AmLo);
        if (!m_lock) begin
          if (good) begin
            e_ok = 1; m_good++;
            if (m_good >= LockN) m_lock = 1;
          end else begin
            e_err = 1; m_sync = 0; m_good = 0; m_prev_hi = 0;
          end
        end else if (good) begin
          e_ok = 1; m_bad = 0;
        end else begin
          e_err = 1; m_bad++;
          if (m_bad >= UnlockN) begin
            m_lock = 0; m_sync = 0; m_bad = 0; m_good = 0; m_prev_hi = 0;
          end
        end
      end
      m_fpos = (m_fpos + 1) % F;
    end
    e_locked = m_lock;
  endtask

  task automatic observe();
    chk_bit("o_valid", lane.o_valid, e_valid);
    chk_bit("o_am_ok", lane.o_am_ok, e_ok);
    chk_bit("o_am_err", lane.o_am_err, e_err);
    chk_bit("o_locked", lane.o_locked, e_locked);
    chk_word("o_data", lane.o_data, e_data);
    if (lane.o_am_ok) ok_cnt++;
    if (lane.o_am_err) err_cnt++;
    if (lane.o_valid) begin
      out_cnt++;
      if (collect) outq.push_back(lane.o_data);
    end
    if (lane.o_locked && !prev_locked) begin
      lock_rose = 1;
      if (lock_at < 0) lock_at = vw_sent;
    end
    if (!lane.o_locked && prev_locked) lock_fell = 1;
    prev_locked = lane.o_locked;
  endtask

  task automatic step(input logic v, input logic [63:0] d);
    @(negedge clk);
    observe();
    lane.i_valid = v;
    lane.i_data  = d;
    if (v) begin
      vw_sent++;
      model_word(d);
    end else begin
      e_valid = 0; e_ok = 0; e_err = 0;
    end
  endtask

  function automatic bit want_idle();
    return (gap_mode == 1 && cyc % 3 == 0) || (gap_mode == 2 && $urandom_range(0, 3) == 0);
  endfunction

  task automatic send_word(input logic [63:0] d);
    cyc++;
    while (want_idle()) begin
      step(1'b0, rnd64());
      cyc++;
    end
    step(1'b1, d);
  endtask

  // kind: 0 good pair, 1 AM_LO zeroed, 2 AM_HI corrupted, 3 no marker at all.
  task automatic send_frame(input int kind);
    for (int i = 0; i < P; i++) begin
      send_word(pay);
      pay = pay + 64'd1;
    end
    case (kind)
      1:       begin send_word(AmHi); send_word(64'd0); end
      2:       begin send_word(AmHi ^ {32'd0, $urandom | 32'd1}); send_word(AmLo); end
      3:       begin send_word(rnd64()); send_word(rnd64()); end
      default: begin send_word(AmHi); send_word(AmLo); end
    endcase
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk_bit("rst_o_valid", lane.o_valid, 1'b0);
    chk_bit("rst_o_am_ok", lane.o_am_ok, 1'b0);
    chk_bit("rst_o_am_err", lane.o_am_err, 1'b0);
    chk_bit("rst_o_locked", lane.o_locked, 1'b0);
    chk_word("rst_o_data", lane.o_data, 64'd0);
    model_reset();
    prev_locked = 0;
    step(1'b0, 64'd0);
    step(1'b0, 64'd0);
    rst_n = 1'b1;
  endtask

  task automatic clear_obs();
    ok_cnt = 0; err_cnt = 0; out_cnt = 0; vw_sent = 0; lock_at = -1;
    lock_fell = 0; lock_rose = 0;
  endtask

  initial begin
    lane.i_valid = 1'b0;
    lane.i_data  = '0;
    gap_mode = 0; cyc = 0; collect = 0; prev_locked = 0;
    clear_obs();
    #2;
    do_reset();

    // Clean stream after a random-length junk prefix.
    k    = $urandom_range(3, 30);
    base = rnd64() >> 8;
    pay  = base;
    clear_obs();
    collect = 1;
    repeat (k) send_word(rnd64());
    repeat (5) send_frame(0);
    step(1'b0, 64'd0);
    collect = 0;
    refq = outq;
    chk_int("clean_lock_at", lock_at, k + LockN * F);
    chk_int("clean_ok_cnt", ok_cnt, 4);
    chk_int("clean_err_cnt", err_cnt, 0);
    chk_int("clean_payload_cnt", out_cnt, 2 * P);
    chk_word("clean_first_payload", (refq.size() > 0) ? refq[0] : 64'd0,
             base + 64'(LockN * P));

    // One bad pair while locked.
    clear_obs();
    send_frame(1);
    send_frame(0);
    step(1'b0, 64'd0);
    chk_int("single_bad_err_cnt", err_cnt, 1);
    chk_int("single_bad_ok_cnt", ok_cnt, 1);
    chk_bit("single_bad_lock_held", lock_fell, 1'b0);
    chk_int("single_bad_payload_cnt", out_cnt, 2 * P);

    // Lock loss over consecutive bad pairs.
    clear_obs();
    repeat (UnlockN) send_frame(2);
    step(1'b0, 64'd0);
    chk_int("loss_err_cnt", err_cnt, UnlockN);
    chk_int("loss_ok_cnt", ok_cnt, 0);
    chk_bit("loss_locked", lane.o_locked, 1'b0);
    chk_int("loss_payload_cnt", out_cnt, UnlockN * P);

    // Isolated marker pair followed by frames without markers.
    clear_obs();
    send_frame(0);
    send_frame(3);
    send_frame(3);
    step(1'b0, 64'd0);
    chk_int("false_lock_err_cnt", err_cnt, 1);
    chk_int("false_lock_ok_cnt", ok_cnt, 0);
    chk_bit("false_lock_rose", lock_rose, 1'b0);
    chk_int("false_lock_payload_cnt", out_cnt, 0);

    // Lock, then reset mid-frame and re-acquire from scratch.
    clear_obs();
    repeat (LockN) send_frame(0);
    repeat ($urandom_range(1, P - 1)) begin
      send_word(pay);
      pay = pay + 64'd1;
    end
    #3;
    do_reset();
    clear_obs();
    pay = base;
    repeat (k) send_word(rnd64());
    repeat (LockN - 1) send_frame(0);
    step(1'b0, 64'd0);
    chk_bit("relock_early", lock_rose, 1'b0);
    send_frame(0);
    step(1'b0, 64'd0);
    chk_int("relock_at", lock_at, k + LockN * F);

    // Clean stream again with every third cycle idle.
    #3;
    do_reset();
    clear_obs();
    outq.delete();
    gap_mode = 1;
    cyc = 0;
    pay = base;
    collect = 1;
    repeat (k) send_word(rnd64());
    repeat (5) send_frame(0);
    step(1'b0, 64'd0);
    collect = 0;
    chk_int("gapped_lock_at", lock_at, k + LockN * F);
    chk_int("gapped_payload_cnt", outq.size(), refq.size());
    for (int i = 0; i < refq.size() && i < outq.size(); i++) begin
      chk_word("gapped_payload", outq[i], refq[i]);
    end

    // Random gaps and random marker corruption, model-checked each cycle.
    gap_mode = 2;
    repeat (40) begin
      case ($urandom_range(0, 7))
        5:       send_frame(1);
        6:       send_frame(2);
        7:       send_frame(3);
        default: send_frame(0);
      endcase
    end
    step(1'b0, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
